// File: rtl/rv_mem_pkg.sv
// rv_mem_pkg: shared response-owner type, word size and byte-to-word address helper for rv_mem_arbiter
package rv_mem_pkg;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_LS} owner_t;
  localparam int WORD_BYTES = 4;
  function automatic logic [29:0] word_idx(input logic [31:0] addr);
    return 30'(addr / WORD_BYTES);
  endfunction
endpackage

// File: rtl/rv_starve_cnt.sv
// rv_starve_cnt: saturating count of denied fetch cycles (clk, reset, if_req, if_gnt in; force_if out when count hits MAX_WAIT)
module rv_starve_cnt #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic if_req,
  input  logic if_gnt,
  output logic force_if
);
  localparam int CW = $clog2(MAX_WAIT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb cnt_d = (!if_req || if_gnt) ? '0 : (cnt_q == CW'(MAX_WAIT)) ? cnt_q : cnt_q + 1'b1;
  always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;
  assign force_if = cnt_q == CW'(MAX_WAIT);
endmodule

// File: rtl/rv_mem_arbiter.sv
// rv_mem_arbiter: data-priority arbiter of fetch (if_*) and load/store (ls_*) onto one 1-cycle memory (mem_*); RV_MEM_ARB_STARVE_EN adds forced fetch after MAX_WAIT denials
module rv_mem_arbiter
  import rv_mem_pkg::*;
#(
  parameter int DEPTH    = 256,
  parameter int AW       = 8,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [31:0]   if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [31:0]   if_rdata,
  output logic          if_err,
  input  logic          ls_req,
  input  logic          ls_we,
  input  logic [31:0]   ls_addr,
  input  logic [31:0]   ls_wdata,
  output logic          ls_gnt,
  output logic          ls_rvalid,
  output logic [31:0]   ls_rdata,
  output logic          ls_err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);
  owner_t      own_q, own_d;
  logic        err_q, err_d, st_q, st_d;
  logic        force_if, ls_win, if_win;
  logic [29:0] idx;
`ifdef RV_MEM_ARB_STARVE_EN
  rv_starve_cnt #(.MAX_WAIT(MAX_WAIT)) u_starve (
    .clk      (clk),
    .reset    (reset),
    .if_req   (if_req),
    .if_gnt   (if_gnt),
    .force_if (force_if)
  );
`else
  assign force_if = 1'b0;
`endif
  always_comb begin
    ls_win    = !reset && ls_req && !(force_if && if_req);
    if_win    = !reset && if_req && !ls_win;
    idx       = word_idx(ls_win ? ls_addr : if_addr);
    err_d     = idx >= 30'(DEPTH);
    st_d      = ls_win && ls_we;
    own_d     = ls_win ? OWN_LS : if_win ? OWN_IF : OWN_NONE;
    if_gnt    = if_win;
    ls_gnt    = ls_win;
    mem_en    = (ls_win || if_win) && !err_d;
    mem_we    = mem_en && st_d;
    mem_addr  = reset ? '0 : idx[AW-1:0];
    mem_wdata = reset ? '0 : ls_wdata;
    if_rvalid = !reset && own_q == OWN_IF;
    ls_rvalid = !reset && own_q == OWN_LS;
    if_err    = if_rvalid && err_q;
    ls_err    = ls_rvalid && err_q;
    if_rdata  = (if_rvalid && !err_q) ? mem_rdata : '0;
    ls_rdata  = (ls_rvalid && !err_q && !st_q) ? mem_rdata : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      own_q <= OWN_NONE;
      err_q <= 1'b0;
      st_q  <= 1'b0;
    end else begin
      own_q <= own_d;
      err_q <= err_d;
      st_q  <= st_d;
    end
  end
endmodule

// File: tb/tb_rv_mem_arbiter.sv
// tb_rv_mem_arbiter: directed and randomized checks of rv_mem_arbiter against a behavioural memory/arbitration model
module tb_rv_mem_arbiter;
  localparam int DEPTH = 256, AW = 8, MAX_WAIT = 4;
  logic clk = 0, reset = 1;
  logic if_req, ls_req, ls_we;
  logic [31:0] if_addr, ls_addr, ls_wdata;
  logic if_gnt, if_rvalid, if_err, ls_gnt, ls_rvalid, ls_err, mem_en, mem_we;
  logic [31:0] if_rdata, ls_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  int checks = 0, errors = 0;
  logic [31:0] mem [0:DEPTH-1];
  logic [31:0] ref_mem [0:DEPTH-1];
  logic bd_we = 0;
  logic [AW-1:0] bd_addr = '0;
  logic [31:0] bd_data = '0;

  always #5 clk = ~clk;

  rv_mem_arbiter #(.DEPTH(DEPTH), .AW(AW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_gnt(ls_gnt),
    .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata), .ls_err(ls_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
    end
  end

  task automatic idle();
    if_req = 0; ls_req = 0; ls_we = 0; if_addr = 0; ls_addr = 0; ls_wdata = 0;
  endtask

  task automatic poke(input int a, input logic [31:0] d);
    @(negedge clk); bd_we = 1; bd_addr = a[AW-1:0]; bd_data = d; ref_mem[a] = d;
    @(negedge clk); bd_we = 0;
  endtask

  task automatic test_init();
    @(negedge clk); bd_we = 1;
    for (int i = 0; i < DEPTH; i++) begin
      bd_addr = i[AW-1:0]; bd_data = $urandom; ref_mem[i] = bd_data;
      @(negedge clk);
    end
    bd_we = 0;
  endtask

  task automatic test_reset();
    @(negedge clk); if_req = 1; ls_req = 1; ls_addr = 32'h20; if_addr = 32'h10;
    #1 checks++;
    if ({if_gnt, ls_gnt, if_rvalid, ls_rvalid, if_err, ls_err, mem_en, mem_we, if_rdata, ls_rdata} !== '0) begin
      errors++; $display("FAIL reset_outputs got %h exp 0", {if_gnt, ls_gnt, if_rvalid, ls_rvalid, if_err, ls_err, mem_en, mem_we, if_rdata, ls_rdata});
    end
    @(negedge clk); idle(); reset = 0;
    @(negedge clk); checks++;
    if ({if_gnt, ls_gnt, if_rvalid, ls_rvalid, mem_en} !== '0) begin
      errors++; $display("FAIL post_reset_idle got %b exp 0", {if_gnt, ls_gnt, if_rvalid, ls_rvalid, mem_en});
    end
  endtask

  task automatic test_fetch();
    poke(4, 32'hDEADBEEF);
    @(negedge clk); if_req = 1; if_addr = 32'h10;
    #1 checks++;
    if ({if_gnt, ls_gnt, mem_en, mem_we, mem_addr} !== {4'b1010, 8'd4}) begin
      errors++; $display("FAIL fetch_grant got %b exp %b", {if_gnt, ls_gnt, mem_en, mem_we, mem_addr}, {4'b1010, 8'd4});
    end
    @(negedge clk); checks++;
    if ({if_rvalid, if_err, if_rdata} !== {2'b10, 32'hDEADBEEF}) begin
      errors++; $display("FAIL fetch_resp got %b/%b/%h exp 1/0/deadbeef", if_rvalid, if_err, if_rdata);
    end
    idle();
  endtask

  task automatic test_contention();
    poke(8, 32'h55);
    @(negedge clk); if_req = 1; if_addr = 32'h30; ls_req = 1; ls_we = 0; ls_addr = 32'h20;
    #1 checks++;
    if ({ls_gnt, if_gnt} !== 2'b10) begin errors++; $display("FAIL contend_first got %b exp 10", {ls_gnt, if_gnt}); end
    @(negedge clk); checks++;
    if ({ls_rvalid, if_rvalid, ls_rdata} !== {2'b10, 32'h55}) begin
      errors++; $display("FAIL contend_ls_resp got %b%b %h exp 10 00000055", ls_rvalid, if_rvalid, ls_rdata);
    end
    ls_req = 0;
    #1 checks++;
    if ({ls_gnt, if_gnt} !== 2'b01) begin errors++; $display("FAIL contend_second got %b exp 01", {ls_gnt, if_gnt}); end
    @(negedge clk); checks++;
    if ({if_rvalid, ls_rvalid, if_rdata} !== {2'b10, ref_mem[12]}) begin
      errors++; $display("FAIL contend_if_resp got %b%b %h exp 10 %h", if_rvalid, ls_rvalid, if_rdata, ref_mem[12]);
    end
    idle();
  endtask

  task automatic test_store_load();
    @(negedge clk); ls_req = 1; ls_we = 1; ls_addr = 32'h40; ls_wdata = 32'h1234;
    #1 checks++;
    if ({ls_gnt, mem_en, mem_we, mem_addr, mem_wdata} !== {3'b111, 8'd16, 32'h1234}) begin
      errors++; $display("FAIL store_grant got %h exp %h", {ls_gnt, mem_en, mem_we, mem_addr, mem_wdata}, {3'b111, 8'd16, 32'h1234});
    end
    ref_mem[16] = 32'h1234;
    @(negedge clk); checks++;
    if ({ls_rvalid, ls_err, ls_rdata} !== {2'b10, 32'h0}) begin
      errors++; $display("FAIL store_ack got %b/%b/%h exp 1/0/0", ls_rvalid, ls_err, ls_rdata);
    end
    ls_we = 0;
    @(negedge clk); checks++;
    if ({ls_rvalid, ls_rdata} !== {1'b1, 32'h1234}) begin
      errors++; $display("FAIL load_after_store got %b/%h exp 1/1234", ls_rvalid, ls_rdata);
    end
    idle();
  endtask

  task automatic test_out_of_range();
    @(negedge clk); ls_req = 1; ls_we = 1; ls_addr = 32'h400; ls_wdata = 32'hCAFEF00D;
    #1 checks++;
    if ({ls_gnt, mem_en} !== 2'b10) begin errors++; $display("FAIL oor_store_grant got %b exp 10", {ls_gnt, mem_en}); end
    @(negedge clk); checks++;
    if ({ls_rvalid, ls_err, ls_rdata} !== {2'b11, 32'h0}) begin
      errors++; $display("FAIL oor_store_resp got %b/%b/%h exp 1/1/0", ls_rvalid, ls_err, ls_rdata);
    end
    ls_we = 0;
    #1 checks++;
    if ({ls_gnt, mem_en} !== 2'b10) begin errors++; $display("FAIL oor_load_grant got %b exp 10", {ls_gnt, mem_en}); end
    @(negedge clk); checks++;
    if ({ls_rvalid, ls_err, ls_rdata} !== {2'b11, 32'h0}) begin
      errors++; $display("FAIL oor_load_resp got %b/%b/%h exp 1/1/0", ls_rvalid, ls_err, ls_rdata);
    end
    ls_addr = 32'h0;
    @(negedge clk); checks++;
    if ({ls_rvalid, ls_err, ls_rdata} !== {2'b10, ref_mem[0]}) begin
      errors++; $display("FAIL oor_mem_intact got %b/%b/%h exp 1/0/%h", ls_rvalid, ls_err, ls_rdata, ref_mem[0]);
    end
    idle();
  endtask

  task automatic test_reset_mid();
    @(negedge clk); ls_req = 1; ls_we = 0; ls_addr = 32'h20;
    #1 checks++;
    if (ls_gnt !== 1'b1) begin errors++; $display("FAIL mid_reset_grant got %b exp 1", ls_gnt); end
    @(negedge clk); ls_req = 0; reset = 1;
    #1 checks++;
    if ({ls_rvalid, ls_rdata} !== '0) begin errors++; $display("FAIL mid_reset_drop got %b/%h exp 0/0", ls_rvalid, ls_rdata); end
    @(negedge clk); reset = 0;
    #1 checks++;
    if ({if_gnt, ls_gnt, if_rvalid, ls_rvalid, if_err, ls_err, mem_en, mem_we, if_rdata, ls_rdata} !== '0) begin
      errors++; $display("FAIL after_reset_outputs got %h exp 0", {if_gnt, ls_gnt, if_rvalid, ls_rvalid, if_err, ls_err, mem_en, mem_we, if_rdata, ls_rdata});
    end
    @(negedge clk); checks++;
    if ({ls_rvalid, if_rvalid} !== 2'b00) begin errors++; $display("FAIL after_reset_rvalid got %b exp 00", {ls_rvalid, if_rvalid}); end
  endtask

  task automatic test_starve();
    int first = 0, exp_first;
`ifdef RV_MEM_ARB_STARVE_EN
    exp_first = MAX_WAIT + 1;
`else
    exp_first = 0;
`endif
    @(negedge clk); if_req = 1; if_addr = 32'h10; ls_req = 1; ls_we = 0; ls_addr = 32'h20;
    for (int c = 1; c <= 8; c++) begin
      #1 if (if_gnt && first == 0) first = c;
      @(negedge clk);
    end
    checks++;
    if (first !== exp_first) begin errors++; $display("FAIL starve_first_if_gnt got %0d exp %0d", first, exp_first); end
    idle();
    @(negedge clk);
  endtask

  function automatic logic [31:0] gen_addr();
    int r = $urandom_range(0, 15);
    if (r == 0) return $urandom;
    if (r < 8) return (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
    return (32'($urandom_range(0, DEPTH + 7)) << 2) | 32'($urandom_range(0, 3));
  endfunction

  task automatic test_random();
    bit p_if = 0, p_ls = 0, p_e = 0, g_if = 0, g_ls = 0, frc, e_if, e_ls, e_en, oor;
    logic [31:0] p_d = 0, a;
    int wait_n = 0, idx;
    idle(); @(negedge clk);
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      checks++;
      if ({if_rvalid, if_err, if_rdata} !== {p_if, p_if && p_e, p_if ? p_d : 32'h0}) begin
        errors++; $display("FAIL rand_if_resp n=%0d got %b/%b/%h exp %b/%b/%h", n, if_rvalid, if_err, if_rdata, p_if, p_if && p_e, p_if ? p_d : 32'h0);
      end
      checks++;
      if ({ls_rvalid, ls_err, ls_rdata} !== {p_ls, p_ls && p_e, p_ls ? p_d : 32'h0}) begin
        errors++; $display("FAIL rand_ls_resp n=%0d got %b/%b/%h exp %b/%b/%h", n, ls_rvalid, ls_err, ls_rdata, p_ls, p_ls && p_e, p_ls ? p_d : 32'h0);
      end
      if (!(if_req && !g_if) || $urandom_range(0, 9) == 0) begin if_req = $urandom_range(0, 1) == 1; if_addr = gen_addr(); end
      if (!(ls_req && !g_ls) || $urandom_range(0, 9) == 0) begin
        ls_req = $urandom_range(0, 1) == 1; ls_we = $urandom_range(0, 1) == 1; ls_addr = gen_addr(); ls_wdata = $urandom;
      end
      #1;
`ifdef RV_MEM_ARB_STARVE_EN
      frc = wait_n >= MAX_WAIT;
`else
      frc = 0;
`endif
      e_ls = ls_req && !(frc && if_req);
      e_if = if_req && !e_ls;
      a = e_ls ? ls_addr : if_addr;
      oor = (a >> 2) >= DEPTH;
      idx = int'(a[AW+1:2]);
      e_en = (e_if || e_ls) && !oor;
      checks++;
      if ({if_gnt, ls_gnt, mem_en} !== {e_if, e_ls, e_en}) begin
        errors++; $display("FAIL rand_grant n=%0d got %b exp %b", n, {if_gnt, ls_gnt, mem_en}, {e_if, e_ls, e_en});
      end
      if (e_en) begin
        checks++;
        if ({mem_addr, mem_we} !== {idx[AW-1:0], e_ls && ls_we}) begin
          errors++; $display("FAIL rand_mem_ctl n=%0d got %h/%b exp %h/%b", n, mem_addr, mem_we, idx[AW-1:0], e_ls && ls_we);
        end
        if (e_ls && ls_we) begin
          checks++;
          if (mem_wdata !== ls_wdata) begin errors++; $display("FAIL rand_wdata n=%0d got %h exp %h", n, mem_wdata, ls_wdata); end
        end
      end
      p_if = e_if; p_ls = e_ls; p_e = oor;
      p_d = (oor || (e_ls && ls_we)) ? 32'h0 : ref_mem[idx];
      if (e_ls && ls_we && !oor) ref_mem[idx] = ls_wdata;
      wait_n = (if_req && !e_if) ? ((wait_n + 1 > MAX_WAIT) ? MAX_WAIT : wait_n + 1) : 0;
      g_if = e_if; g_ls = e_ls;
    end
    @(negedge clk); idle();
    @(negedge clk);
  endtask

  initial begin
    idle();
    test_init();
    test_reset();
    test_fetch();
    test_contention();
    test_store_load();
    test_out_of_range();
    test_reset_mid();
    test_starve();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
